instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Front-end fetch stage that produces the instruction stream consumed by the control unit and register-file decode. Holds the PC, issues word reads to instruction memory over a valid/ready request and an in-order response channel, buffers returned words with their PCs, and presents them to decode over a valid/ready handshake. Redirects from branch/jump resolution flush buffered and in-flight instructions and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, fetch-buffer entries (power of two, ≥2); also bounds in-flight requests
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  taken branch or jump this cycle
- redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0
- imem_req_valid  out  1  read request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned read address
- imem_rsp_valid  in  1  read data returned, in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  if_instr/if_pc valid
- if_ready  in  1  decode accepts
- if_instr  out  32  instruction to decode (opcode [6:0], funct3 [14:12], funct7 [31:25])
- if_pc  out  32  PC of if_instr

## Operation
- Registers: fetch_pc, rsp_pc, outstanding (accepted, not yet responded), discard_cnt, buffer of {pc, instr}.
- pop = if_valid & if_ready. credit = DEPTH − count − outstanding + pop.
- imem_req_valid = (credit > 0) & ~redirect_valid; imem_req_addr = fetch_pc. Request may be withdrawn; only valid&ready cycles count as accepted.
- Accept: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response: outstanding −= 1. If discard_cnt > 0: word dropped, discard_cnt −= 1. Else push {rsp_pc, imem_rsp_data}, rsp_pc += 4.
- Push and pop in same cycle legal; count unchanged. Push never meets a full buffer by construction of credit; overflow is a design error, flagged by assertion.
- Redirect (highest priority): buffer flushed (if_valid low next cycle; pop in redirect cycle ignored by decode and does not matter), fetch_pc and rsp_pc ← {redirect_pc[31:2], 2'b00}, discard_cnt ← outstanding − imem_rsp_valid (all older in-flight words dropped, including ones already being discarded), no request issued that cycle.
- Response arriving in the redirect cycle is dropped.
- Back-to-back redirects: each recomputes discard_cnt from current outstanding; latest target wins.
- Reset mid-operation: all state cleared immediately; responses to pre-reset requests are not tolerated (memory must be reset with the same rst).

## Timing
- Reset values: imem_req_valid 1 (credit = DEPTH), imem_req_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0; fetch_pc = rsp_pc = RESET_PC, outstanding = discard_cnt = count = 0.
- Latency: request accepted cycle N, response cycle N+k, if_valid earliest N+k+1 (buffer is registered, no response-to-output bypass).
- Throughput: 1 instruction/cycle sustained with k=1 memory and continuous if_ready.
- Redirect in cycle R: first request to target in R+1; first target instruction at if_valid R+3 with k=1.
- if_instr/if_pc held stable while if_valid & ~if_ready.
- Combinational path if_ready → imem_req_valid accepted; no path imem_rsp_* → if_*.

## Structure
- defines.v additions: `RESET_PC, `XLEN (32), `INSTR_NOP (32'h0000_0013).
- One sub-module: fetch_fifo, synchronous DEPTH-entry FIFO of {pc, instr} with push, pop, flush, count; pointers wrap via power-of-two DEPTH.
- Counters outstanding/discard_cnt sized $clog2(DEPTH)+1.

## Test plan
- Reset release, 1-cycle memory, if_ready=1 → addresses 0x0,0x4,0x8… on consecutive cycles; if_pc 0x0 at cycle 2, then +4 each cycle.
- if_ready=0 for 10 cycles → exactly 4 words buffered, imem_req_valid low once credit 0, if_instr 0x0 held; release → in-order drain, no loss.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped, next if_pc 0x100, no 0x8/0xC instructions delivered.
- Redirect same cycle as response, target 0x203 → response dropped, fetch at 0x200, if_pc 0x200.
- Random memory latency 1–5 and random imem_req_ready/if_ready → delivered (pc, instr) sequence matches golden sequential model; no overflow assertion.
- Assert rst while 3 requests outstanding → outputs return to reset values same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// A fetch-buffer entry pairs each instruction word with the PC it was fetched from.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, instr} with flush; pointers wrap naturally
// because DEPTH is a power of two. Storage is not reset, only the control state.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign not_empty = (count != '0);
  assign push_ok   = push & ~flush;
  assign pop_ok    = pop & not_empty & ~flush;
  // Gate the head so the outputs read zero whenever nothing is buffered.
  assign head      = not_empty ? slots[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      slots[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      assert (count != CW'(DEPTH) || pop_ok)
        else $error("fetch_fifo: push into full buffer");
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order word reads, buffers returned words with their PCs,
// and hands them to decode. Redirects flush the buffer and discard in-flight words.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CRW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;
  logic [CW-1:0]   count;
  logic [CRW-1:0]  credit;
  logic            pop;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop_old;
  logic [XLEN-1:0] target_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign pop = if_valid & if_ready;

  // Every buffered word and every in-flight request holds a slot, so a response
  // can always be pushed; a same-cycle pop frees one slot early.
  assign credit = CRW'(DEPTH) - {1'b0, count} - {1'b0, outstanding} + CRW'(pop);

  assign imem_req_valid = (credit != '0) & ~redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep     = imem_rsp_valid & ~redirect_valid & (discard_cnt == '0);
  assign rsp_drop_old = imem_rsp_valid & ~redirect_valid & (discard_cnt != '0);
  assign target_pc    = word_align(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc    <= target_pc;
        rsp_pc      <= target_pc;
        discard_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (rsp_drop_old) begin
          discard_cnt <= discard_cnt - CW'(1);
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert (outstanding != '0)
        else $error("instr_fetch_unit: response with no request outstanding");
    end
  end

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .not_empty  (if_valid),
    .count      (count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule
